uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Receive side of the UART controller: deserialises the asynchronous serial line into characters using 16x oversampling.
- Driven by the same 16x baud `enable` strobe and `lcr` register as the transmit path.
- Checks parity, stop bit and break.
- Pushes each completed character plus its error flags into the RX FIFO through a single-cycle push interface.

Parameters:
- SYNC_STAGES, 2, number of flops in the serial_in synchroniser (minimum 2).

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  16x baud strobe, one clk cycle wide
- lcr  input  8  line control: [1:0] word length 5..8, [2] stop bits, [3] parity enable, [4] even parity, [5] stick parity, [6] break control
- rx_reset  input  1  abort the current frame, return to idle
- serial_in  input  1  asynchronous serial line, idle high
- rf_push  output  1  one-cycle push strobe to the RX FIFO
- rf_data  output  11  {break, framing_err, parity_err, data[7:0]}; unused upper data bits are 0
- rstate  output  3  current FSM state, for the debug register
- rx_active  output  1  high in every state except idle

Behaviour:
- Reset and rx_reset produce the same result:
  - rstate=idle, rf_push=0, rf_data=0, rx_active=0, counters=0.
  - Synchroniser flops are set to 1.
  - rx_reset has priority over enable.
- serial_in passes through SYNC_STAGES flops; `srx` below means the synchronised value.
- The FSM and counters advance only on cycles with enable=1. The exceptions are rf_push clear and the reset paths.
- States (3-bit encoding):
  - idle=0: on enable with srx=0, load counter=7 and go to start.
  - start=1: decrement counter on each enable. At counter==0, sample srx:
    - srx=1: false start, go to idle.
    - srx=0: load counter=15, load bit_cnt=word length-1 (4..7), clear the shift register, go to data.
  - data=2: at counter==0, shift srx in LSB-first and reload counter=15. When bit_cnt==0 the last bit has been taken; go to parity if lcr[3]=1, else stop. Otherwise decrement bit_cnt.
  - parity=3: at counter==0, sample the parity bit and compute the error:
    - Expected bit: lcr[5:4]=00 → ~^data; 01 → ^data; 10 → 1; 11 → 0. The XOR covers only the received bits.
    - parity_err = sampled ≠ expected.
    - Reload counter=15, go to stop.
  - stop=4: at counter==0, sample the stop bit. framing_err = ~srx. Then:
    - Assert rf_push for exactly one clk cycle, on the cycle after this enable.
    - Go to idle if srx=1, else go to wait_high.
    - Only the first stop bit is checked, regardless of lcr[2].
  - wait_high=5: stay until an enable with srx=1, then go to idle. This prevents a held-low line being decoded as repeated frames.
  - Codes 6 and 7 are illegal and return to idle on the next clk.
- Bit sampling lands mid-bit:
  - Start edge is seen at enable N.
  - Start is sampled at N+8.
  - Data bit k is sampled at N+8+16(k+1).
- break = 1 when all received data bits, the parity bit (if enabled) and the stop bit are all 0. break implies framing_err=1.
- rf_data holds its value until the next push.
- An lcr change mid-frame is undefined. lcr is sampled when the frame leaves start; the implementation latches word length at that point.
- lcr[6] (break control) is ignored by the receiver.
- rf_push is never asserted while enable is low except in the cycle right after the stop-sample enable.

Decomposition:
- Shared package (uart_defines.vh) holds:
  - LCR bit-position defines, shared with the transmit path.
  - The RX state encodings.
  - UART_FIFO_REC_WIDTH=11.
  - rf_data field offsets.
- Sub-module uart_sync: a parameterised N-flop synchroniser with a reset value of 1. It is reusable for modem inputs.
- The FSM, counters and checks stay in uart_receiver.

Test Plan:
- 8N1, byte 0xA5, enable every 4 clk, 16 enables per bit → one rf_push; rf_data=0x0A5. rstate returns to 0 one enable after the stop sample.
- 7E1, lcr=0x1A, byte 0x55 sent with wrong parity bit 1 → rf_data=0x155 (parity_err=1, data=0x55).
- 5N1, lcr=0x00, byte 0x1F with stop bit driven 0 → rf_data=0x21F (framing_err=1); FSM sits in wait_high=5 until the line goes high.
- Line held low for 3 frame times (8N1) → exactly one push with rf_data=0x600 (break plus framing); no further pushes until the line goes high, then idle.
- Glitch: serial_in low for 5 enables then high → no rf_push; rstate goes 0→1→0.
- rx_reset pulsed during data (bit 3 of 8) → rstate=0 next clk, no push. A following clean 0x3C frame yields rf_data=0x03C.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared UART receive definitions: LCR bit positions, RX state encodings,
// RX FIFO record layout and the parity helper.
package uart_receiver_pkg;

  localparam int LCR_WLS_LO = 0;
  localparam int LCR_STB    = 2;
  localparam int LCR_PEN    = 3;
  localparam int LCR_EPS    = 4;
  localparam int LCR_SP     = 5;
  localparam int LCR_BC     = 6;

  localparam int UART_FIFO_REC_WIDTH = 11;
  localparam int RF_BREAK = 10;
  localparam int RF_FE    = 9;
  localparam int RF_PE    = 8;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  // mode = {stick, even}; unreceived data bits are zero so they drop out of the XOR
  function automatic logic parity_expected(input logic [1:0] mode, input logic [7:0] d);
    case (mode)
      2'b00:   return ~^d;
      2'b01:   return ^d;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for asynchronous UART lines; resets to the idle-high level.
module uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset || clr) ff <= '1;
    else              ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: 16x oversampled deserialiser with parity, framing and
// break detection, pushing one 11-bit record per frame into the RX FIFO.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [7:0]                     lcr,
  input  logic                           rx_reset,
  input  logic                           serial_in,
  output logic                           rf_push,
  output logic [UART_FIFO_REC_WIDTH-1:0] rf_data,
  output logic [2:0]                     rstate,
  output logic                           rx_active
);

  logic srx;

  uart_sync #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .clr   (rx_reset),
    .d     (serial_in),
    .q     (srx)
  );

  rx_state_t state, st_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] bit_cnt, bc_n;
  logic [2:0] wl_m1, wl_n;
  logic [7:0] shreg, sh_n;
  logic [1:0] pmode, pmode_n;
  logic       pen, pen_n;
  logic       par_err, pe_n;
  logic       par_zero, pz_n;
  logic       push_n;
  logic [UART_FIFO_REC_WIDTH-1:0] data_n;
  logic [2:0] idx;
  logic       brk;

  // stop-bit count and break control do not affect reception
  logic unused_lcr;
  assign unused_lcr = ^{lcr[7], lcr[LCR_BC], lcr[LCR_STB]};

  assign idx = wl_m1 - bit_cnt;
  assign brk = ~srx & par_zero & (shreg == 8'h00);

  always_comb begin
    st_n    = state;
    cnt_n   = cnt;
    bc_n    = bit_cnt;
    wl_n    = wl_m1;
    sh_n    = shreg;
    pmode_n = pmode;
    pen_n   = pen;
    pe_n    = par_err;
    pz_n    = par_zero;
    push_n  = 1'b0;
    data_n  = rf_data;
    case (state)
      RX_IDLE: begin
        if (enable && !srx) begin
          cnt_n = 4'd7;
          st_n  = RX_START;
        end
      end
      RX_START: begin
        if (enable) begin
          if (cnt != 4'd0) cnt_n = cnt - 4'd1;
          else if (srx) st_n = RX_IDLE;
          else begin
            // frame format is frozen here for the rest of the frame
            cnt_n   = 4'd15;
            bc_n    = {1'b1, lcr[LCR_WLS_LO +: 2]};
            wl_n    = {1'b1, lcr[LCR_WLS_LO +: 2]};
            pen_n   = lcr[LCR_PEN];
            pmode_n = {lcr[LCR_SP], lcr[LCR_EPS]};
            sh_n    = 8'h00;
            pe_n    = 1'b0;
            pz_n    = 1'b1;
            st_n    = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (enable) begin
          if (cnt != 4'd0) cnt_n = cnt - 4'd1;
          else begin
            sh_n[idx] = srx;
            cnt_n     = 4'd15;
            if (bit_cnt == 3'd0) st_n = pen ? RX_PARITY : RX_STOP;
            else                 bc_n = bit_cnt - 3'd1;
          end
        end
      end
      RX_PARITY: begin
        if (enable) begin
          if (cnt != 4'd0) cnt_n = cnt - 4'd1;
          else begin
            pe_n  = srx ^ parity_expected(pmode, shreg);
            pz_n  = ~srx;
            cnt_n = 4'd15;
            st_n  = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (enable) begin
          if (cnt != 4'd0) cnt_n = cnt - 4'd1;
          else begin
            push_n = 1'b1;
            data_n = {brk, ~srx, par_err, shreg};
            st_n   = srx ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (enable && srx) st_n = RX_IDLE;
      end
      default: st_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || rx_reset) begin
      state    <= RX_IDLE;
      cnt      <= 4'd0;
      bit_cnt  <= 3'd0;
      wl_m1    <= 3'd0;
      shreg    <= 8'h00;
      pmode    <= 2'b00;
      pen      <= 1'b0;
      par_err  <= 1'b0;
      par_zero <= 1'b0;
      rf_push  <= 1'b0;
      rf_data  <= '0;
    end else begin
      state    <= st_n;
      cnt      <= cnt_n;
      bit_cnt  <= bc_n;
      wl_m1    <= wl_n;
      shreg    <= sh_n;
      pmode    <= pmode_n;
      pen      <= pen_n;
      par_err  <= pe_n;
      par_zero <= pz_n;
      rf_push  <= push_n;
      rf_data  <= data_n;
    end
  end

  assign rstate    = state;
  assign rx_active = (state != RX_IDLE);

endmodule
